// File: rtl/paddle_ctrl.sv
// Paddle movement controller: synchronizes and debounces the buttons, picks a manual or
// ball-tracking request, blocks moves past the screen edges and emits rate-limited move pulses.
module paddle_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_DIV        = 50000,
    parameter int unsigned AI_DEADBAND     = 4,
    parameter int unsigned SCREEN_HEIGHT   = 600
) (
    input  logic       PixelClock,
    input  logic       Reset,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       aiMode,
    input  logic [9:0] ballY,
    input  logic [9:0] paddleTop,
    input  logic [9:0] paddleBottom,
    output logic [1:0] paddleMove
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CMP_W  = 11;
    localparam int unsigned N_SYNC = 3;
    localparam int unsigned N_BTN  = 2;

    // Bit positions inside the synchronizer vectors
    localparam int unsigned IDX_UP = 0;
    localparam int unsigned IDX_DN = 1;
    localparam int unsigned IDX_AI = 2;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [CMP_W-1:0]  DEADBAND  = CMP_W'(AI_DEADBAND);
    localparam logic [CMP_W-1:0]  BOTTOM_LIM = CMP_W'(SCREEN_HEIGHT - 1);
    localparam logic [CMP_W-1:0]  TOP_LIM   = CMP_W'(1);

    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] MOVE_UP   = 2'b01;
    localparam logic [1:0] MOVE_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    logic [N_SYNC-1:0] sync1_q, sync1_d;
    logic [N_SYNC-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0]  db_q, db_d;
    logic [DB_W-1:0]   db_cnt_q [N_BTN];
    logic [DB_W-1:0]   db_cnt_d [N_BTN];

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]        move_q, move_d;

    state_e            manual_req;
    state_e            ai_req;
    state_e            sel_req;
    state_e            gated_req;

    logic [CMP_W-1:0]  pos_sum;
    logic [CMP_W-1:0]  centre;
    logic [CMP_W-1:0]  ball_ext;
    logic [CMP_W-1:0]  top_ext;
    logic [CMP_W-1:0]  bottom_ext;

    // Two-flop synchronizers for all three asynchronous inputs
    always_comb begin
        sync1_d = {aiMode, btnDown, btnUp};
        sync2_d = sync1_q;
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Manual request: opposing buttons cancel each other
    always_comb begin
        manual_req = ST_IDLE;
        if (db_q[IDX_UP] && !db_q[IDX_DN]) begin
            manual_req = ST_UP;
        end else if (db_q[IDX_DN] && !db_q[IDX_UP]) begin
            manual_req = ST_DOWN;
        end
    end

    // Ball tracking: steer the paddle centre towards the ball, with a deadband to avoid dithering
    always_comb begin
        ball_ext   = {1'b0, ballY};
        top_ext    = {1'b0, paddleTop};
        bottom_ext = {1'b0, paddleBottom};
        pos_sum    = top_ext + bottom_ext;
        centre     = pos_sum >> 1;
        ai_req     = ST_IDLE;
        if ((ball_ext + DEADBAND) < centre) begin
            ai_req = ST_UP;
        end else if (ball_ext > (centre + DEADBAND)) begin
            ai_req = ST_DOWN;
        end
    end

    // Source select and screen-edge gating
    always_comb begin
        sel_req   = sync2_q[IDX_AI] ? ai_req : manual_req;
        gated_req = sel_req;
        if ((sel_req == ST_UP) && (top_ext <= TOP_LIM)) begin
            gated_req = ST_IDLE;
        end
        if ((sel_req == ST_DOWN) && (bottom_ext >= BOTTOM_LIM)) begin
            gated_req = ST_IDLE;
        end
    end

    // Direction FSM: a request change restarts the step timer; steady requests pulse every STEP_DIV cycles
    always_comb begin
        state_d    = gated_req;
        step_cnt_d = '0;
        move_d     = MOVE_NONE;
        if ((gated_req == state_q) && (state_q != ST_IDLE)) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                move_d     = (state_q == ST_UP) ? MOVE_UP : MOVE_DOWN;
            end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            step_cnt_q <= '0;
            move_q     <= MOVE_NONE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            move_q     <= move_d;
        end
    end

    assign paddleMove = move_q;

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles (after sync) before a button level is accepted; legal range 1..2^20.
REQ-002 Parameter STEP_DIV, default 50000, cycles between successive move pulses while a direction is held; legal range 1..2^20.
REQ-003 Parameter AI_DEADBAND, default 4, pixel tolerance around paddle centre in AI mode.
REQ-004 Parameter SCREEN_HEIGHT, default 600, screen height in pixels.
REQ-005 PixelClock  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high; priority over all other logic.
REQ-007 btnUp  input  1  raw asynchronous up button, active-high.
REQ-008 btnDown  input  1  raw asynchronous down button, active-high.
REQ-009 aiMode  input  1  raw asynchronous switch; 1 = AI tracks ball, 0 = buttons.
REQ-010 ballY  input  10  ball top y coordinate.
REQ-011 paddleTop  input  10  current paddle top y (from paddle topCollision).
REQ-012 paddleBottom  input  10  current paddle bottom y (from paddle bottomCollision).
REQ-013 paddleMove  output  2  registered move pulse to paddle; bit0 = up (y-1), bit1 = down (y+1).

Function
REQ-014 btnUp, btnDown, aiMode each SHALL pass through a 2-flop synchronizer (s1<=raw, s2<=s1).
REQ-015 Debounce per button: counter cleared when s2 equals debounced level; else incremented; when s2 differs and counter == DEBOUNCE_CYCLES-1, debounced level <= s2 and counter <= 0.
REQ-016 Manual request: UP if dbUp & !dbDown; DOWN if dbDown & !dbUp; both or neither -> NONE.
REQ-017 AI request: centre = (paddleTop + paddleBottom) >> 1 using 11-bit unsigned sum; UP if ballY + AI_DEADBAND < centre; DOWN if ballY > centre + AI_DEADBAND; else NONE; all compares 11-bit unsigned, no wrap.
REQ-018 Source select: synchronized aiMode chooses AI request (1) or manual request (0); aiMode not debounced.
REQ-019 Boundary gating: UP forced to NONE when paddleTop <= 1; DOWN forced to NONE when paddleBottom >= SCREEN_HEIGHT-1.
REQ-020 FSM states IDLE, UP, DOWN; each cycle state <= gated request (NONE -> IDLE); direct UP<->DOWN transitions allowed.
REQ-021 When gated request differs from current state: stepCnt <= 0, paddleMove <= 00.
REQ-022 In UP/DOWN with request unchanged: if stepCnt == STEP_DIV-1 then stepCnt <= 0 and paddleMove <= 01 (UP) or 10 (DOWN); else stepCnt increments, paddleMove <= 00.
REQ-023 In IDLE: stepCnt held at 0, paddleMove <= 00.
REQ-024 paddleMove SHALL never be 11; each pulse lasts exactly one cycle, except STEP_DIV=1 gives continuous assertion.
REQ-025 Latency (manual): with btnUp first sampled high at edge 1 and held, first pulse registered at edge 3+DEBOUNCE_CYCLES+STEP_DIV, then every STEP_DIV edges.
REQ-026 Button glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse.

Reset
REQ-027 On Reset=1 at an edge: synchronizer flops, debounced levels, debounce counters, stepCnt <= 0; state <= IDLE; paddleMove <= 00.
REQ-028 Reset asserted mid-operation SHALL cancel any pending pulse on that edge; after release, behaviour restarts as from power-up (full debounce required again).

Verification (DEBOUNCE_CYCLES=4, STEP_DIV=3, AI_DEADBAND=4, SCREEN_HEIGHT=600)
REQ-029 Hold btnUp=1 from edge 1, paddleTop=100, paddleBottom=250 -> paddleMove=01 after edges 10, 13, 16; 00 elsewhere.
REQ-030 btnUp=1 for 3 cycles then 0 -> paddleMove stays 00 indefinitely.
REQ-031 btnUp and btnDown both held debounced -> paddleMove 00; release btnUp -> first 10 pulse STEP_DIV+1 edges after dbUp falls.
REQ-032 aiMode=1, paddleTop=100, paddleBottom=200 (centre 150): ballY=140 -> 01 pulses every 3 cycles; ballY=150 -> 00; ballY=155 -> 10 pulses.
REQ-033 Hold btnDown with paddleBottom=599 -> paddleMove 00; with paddleTop=1 and btnUp held -> 00.
REQ-034 Assert Reset for 1 cycle during held btnUp pulse train -> paddleMove 00 that edge; next pulse 3+4+3 edges after Reset deasserts.
